fifo_rd_ctrl_mc: RTL and testbench
==================================

// Module: fifo_rd_ctrl_mc
// PURPOSE
//  Multi-channel read-side controller for a shared FIFO memory split into NUM_CH regions of MEM_SIZE words.
//  Tracks per-channel occupancy from write-side push pulses and generates pop, read address and empty flags.
//  Arbitrates consumer reads in round-robin or fixed-channel mode.
//  Issues a registered read-valid aligned with one-cycle memory read latency.
// PARAMETERS
//  NUM_CH    4  number of channels (>=2)
//  MEM_SIZE  4  words per channel; need not be a power of two
//  WORD_SIZE 6  data width; sets memory sizing only, no data path through this block
//  PTR_L     2  read-pointer width, >= clog2(MEM_SIZE)
//  CH_L      2  channel-index width, >= clog2(NUM_CH)
//  CNT_L     3  occupancy-counter width, >= clog2(MEM_SIZE+1)
// PORTS
//  clk          in  1              rising-edge clock
//  reset        in  1              asynchronous, active-high reset
//  push         in  NUM_CH         bit i: one word written to channel i this cycle
//  fifo_rd      in  1              consumer read request; at most one word per cycle
//  rr_mode      in  1              1 = round-robin over non-empty channels; 0 = fixed channel ch_sel
//  ch_sel       in  CH_L           channel selected when rr_mode=0
//  ae_thresh    in  CNT_L          almost-empty threshold, shared by all channels
//  pop          out 1              combinational; a word is read this cycle
//  pop_ch       out CH_L           combinational; channel being popped (0 when pop=0)
//  rd_addr      out CH_L+PTR_L     combinational; {pop_ch, rd_ptr[pop_ch]}
//  fifo_empty   out NUM_CH         bit i: count[i]==0
//  almost_empty out NUM_CH         bit i: count[i]<=ae_thresh
//  occupancy    out NUM_CH*CNT_L   flat vector; channel i is occupancy[i*CNT_L +: CNT_L]
//  rd_valid     out 1              registered pop; memory data is valid this cycle
//  rd_valid_ch  out CH_L           registered pop_ch
// BEHAVIOUR
//  Reset (async, while high):
//   - all rd_ptr and count registers go to 0; last_grant goes to NUM_CH-1 so channel 0 wins first.
//   - rd_valid=0, rd_valid_ch=0.
//   - pop is forced 0 combinationally while reset=1.
//   - reset asserted mid-operation discards all occupancy; no pop completes in that cycle.
//  Grant, fixed mode (rr_mode=0):
//   - pop = fifo_rd & ~fifo_empty[ch_sel]; pop_ch = ch_sel.
//   - ch_sel >= NUM_CH: no pop.
//  Grant, round-robin mode (rr_mode=1):
//   - Scan the non-empty channels starting at last_grant+1 (mod NUM_CH); take the first one found.
//   - pop = fifo_rd & any channel non-empty.
//   - last_grant updates to pop_ch on every pop; it holds when rr_mode=0.
//  Empty and almost-empty flags are decoded from registered counts.
//   - A push to an empty channel becomes poppable in the next cycle, not the same one.
//  Pointers: on a pop, rd_ptr[pop_ch] advances by 1; MEM_SIZE-1 wraps to 0. Other channels hold.
//  Occupancy per channel i, evaluated each cycle:
//   - push & pop: count holds.
//   - push only: count+1, saturating at MEM_SIZE (an overflow push is dropped).
//   - pop only: count-1. Underflow cannot occur because pop requires non-empty.
//  Latency:
//   - pop/rd_addr are combinational from inputs and state (0 cycles).
//   - rd_valid/rd_valid_ch follow pop/pop_ch by exactly 1 cycle.
//  fifo_rd while every eligible channel is empty: no pop, no state change.
// CONFIGURATION
//  FIFO_RD_ERR_EN defined:
//   - Adds ports err_clr (in 1), err_underflow (out 1) and err_overflow (out NUM_CH).
//   - err_underflow: sticky; set when fifo_rd=1 and no pop occurs (reset=0).
//   - err_overflow[i]: sticky; set on a push to channel i while count[i]==MEM_SIZE with no pop on i.
//   - Both clear on reset or on err_clr; if set and clear coincide, set wins.
//  FIFO_RD_ERR_EN undefined: these ports and registers are absent; an overflow push is silently dropped.
// STRUCTURE
//  fifo_params.vh (shared include): clog2 function; default NUM_CH/MEM_SIZE/WORD_SIZE constants.
//   - The write-side controller includes the same header.
//  Sub-module rr_arbiter: parameter N; inputs req[N], last[CH_L]; outputs gnt_idx, gnt_any (combinational).
//  Top level: per-channel pointer/counter generate loop, mode mux, rd_valid pipeline register.
// TESTING
//  1 Reset with 3 words in ch1, then reset pulse -> all counts 0, fifo_empty=4'b1111, rd_valid=0, no pop.
//  2 Fixed mode, ch_sel=2:
//    - 5 pushes into ch2 (MEM_SIZE=4) -> count saturates at 4;
//    - 4 reads -> rd_addr 8,9,10,11, then pointer wraps to 0;
//    - 5th read -> pop=0 (err_underflow=1 with FIFO_RD_ERR_EN).
//  3 Round-robin, ch0/ch1/ch3 each holding 2 words, fifo_rd held high:
//    -> pop_ch sequence 0,1,3,0,1,3; then pop=0;
//    -> rd_valid_ch repeats the sequence delayed by 1 cycle.
//  4 push[1] and pop of ch1 in the same cycle, count=2 -> count stays 2; rd_ptr[1] advances by 1.
//  5 push[0] into empty ch0 with fifo_rd=1 in the same cycle -> no pop that cycle; pop_ch=0 next cycle.
//  6 ae_thresh=1, ch3 count goes 0,1,2,1 -> almost_empty[3]=1,1,0,1; fifo_empty[3]=1,0,0,0.

Source files
------------

// File: rtl/fifo_rd_ctrl_mc_pkg.sv
// Shared definitions for the multi-channel FIFO read controller.
//   - default channel count, words per channel and word width
//   - clog2 helper used to size pointer, channel and counter fields
//   - read-mode encoding
package fifo_rd_ctrl_mc_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_MEM_SIZE  = 4;
    localparam int DEF_WORD_SIZE = 6;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } rd_mode_e;

    // Bits needed to index v distinct values (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_mc_if.sv
// Consumer/producer-facing bus of the FIFO read controller.
//   slave  : the controller (consumes push/read requests, drives pop/address/flags)
//   master : the environment (write side and consumer)
// Error ports exist only when FIFO_RD_ERR_EN is defined.
interface fifo_rd_ctrl_mc_if
    import fifo_rd_ctrl_mc_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int PTR_L  = clog2(DEF_MEM_SIZE),
    parameter int CH_L   = clog2(DEF_NUM_CH),
    parameter int CNT_L  = clog2(DEF_MEM_SIZE + 1)
);
    logic [NUM_CH-1:0]       push;
    logic                    fifo_rd;
    logic                    rr_mode;
    logic [CH_L-1:0]         ch_sel;
    logic [CNT_L-1:0]        ae_thresh;
    logic                    pop;
    logic [CH_L-1:0]         pop_ch;
    logic [CH_L+PTR_L-1:0]   rd_addr;
    logic [NUM_CH-1:0]       fifo_empty;
    logic [NUM_CH-1:0]       almost_empty;
    logic [NUM_CH*CNT_L-1:0] occupancy;
    logic                    rd_valid;
    logic [CH_L-1:0]         rd_valid_ch;
`ifdef FIFO_RD_ERR_EN
    logic                    err_clr;
    logic                    err_underflow;
    logic [NUM_CH-1:0]       err_overflow;
`endif

    modport slave (
`ifdef FIFO_RD_ERR_EN
        input  err_clr,
        output err_underflow,
        output err_overflow,
`endif
        input  push, fifo_rd, rr_mode, ch_sel, ae_thresh,
        output pop, pop_ch, rd_addr, fifo_empty, almost_empty, occupancy,
        output rd_valid, rd_valid_ch
    );

    modport master (
`ifdef FIFO_RD_ERR_EN
        output err_clr,
        input  err_underflow,
        input  err_overflow,
`endif
        output push, fifo_rd, rr_mode, ch_sel, ae_thresh,
        input  pop, pop_ch, rd_addr, fifo_empty, almost_empty, occupancy,
        input  rd_valid, rd_valid_ch
    );

endinterface

// File: rtl/fifo_rd_ctrl_mc_rr_arbiter.sv
// Round-robin picker: scans i_req starting one past i_last (mod N) and returns
// the first requester. Purely combinational.
//   i_req     : N request bits
//   i_last    : most recently granted index
//   o_gnt_idx : granted index (0 when nothing requested)
//   o_gnt_any : at least one request present
module fifo_rd_ctrl_mc_rr_arbiter #(
    parameter int N    = 4,
    parameter int CH_L = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [CH_L-1:0] i_last,
    output logic [CH_L-1:0] o_gnt_idx,
    output logic            o_gnt_any
);

    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        // Offset k=1 is the highest priority; k=N revisits i_last itself.
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!o_gnt_any && i_req[j] && (j == ((int'(i_last) + k) % N))) begin
                    o_gnt_any = 1'b1;
                    o_gnt_idx = CH_L'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl_mc.sv
// Read-side controller for a shared FIFO memory split into NUM_CH regions of
// MEM_SIZE words. Tracks per-channel occupancy from push pulses, arbitrates
// consumer reads (round-robin or fixed channel) and produces the pop, the read
// address and a read-valid registered to match one-cycle memory latency.
// Ports:
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : fifo_rd_ctrl_mc_if.slave (push/fifo_rd/mode in; pop, pop_ch,
//                rd_addr, fifo_empty, almost_empty, occupancy, rd_valid,
//                rd_valid_ch out)
// Build option FIFO_RD_ERR_EN adds sticky err_underflow / err_overflow flags
// with err_clr; without it an overflow push is silently dropped.
module fifo_rd_ctrl_mc
    import fifo_rd_ctrl_mc_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int PTR_L     = 2,
    parameter int CH_L      = 2,
    parameter int CNT_L     = 3
) (
    input logic              clk,
    input logic              reset,
    fifo_rd_ctrl_mc_if.slave bus
);

    // WORD_SIZE only sizes the external memory; it is checked here so that a
    // bad configuration is caught at elaboration.
    if (NUM_CH < 2 || MEM_SIZE < 1 || WORD_SIZE < 1) begin : g_bad_params
        $error("fifo_rd_ctrl_mc: illegal parameter set");
    end

    logic [NUM_CH-1:0][CNT_L-1:0] w_cnt;
    logic [NUM_CH-1:0][PTR_L-1:0] w_ptr;
    logic [NUM_CH-1:0]            w_empty;
    logic [NUM_CH-1:0]            w_aempty;
    logic [CH_L-1:0]              w_gnt_idx;
    logic                         w_gnt_any;
    logic                         w_sel_ok;
    logic                         w_pop;
    logic [CH_L-1:0]              w_pop_ch;
    logic [CH_L-1:0]              r_last;
    logic                         r_rd_valid;
    logic [CH_L-1:0]              r_rd_valid_ch;
`ifdef FIFO_RD_ERR_EN
    logic                         r_err_underflow;
    logic [NUM_CH-1:0]            r_err_overflow;
    logic [NUM_CH-1:0]            w_ovf_set;
`endif

    fifo_rd_ctrl_mc_rr_arbiter #(.N(NUM_CH), .CH_L(CH_L)) u_arb (
        .i_req     (~w_empty),
        .i_last    (r_last),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_sel_ok = int'(bus.ch_sel) < NUM_CH;

    // Mode mux. Flags come from registered counts, so a word pushed this
    // cycle cannot be popped until the next one.
    always_comb begin
        w_pop    = 1'b0;
        w_pop_ch = '0;
        if (!reset) begin
            if (rd_mode_e'(bus.rr_mode) == MODE_RR) begin
                w_pop = bus.fifo_rd & w_gnt_any;
                if (w_pop) w_pop_ch = w_gnt_idx;
            end else begin
                w_pop = bus.fifo_rd & w_sel_ok & ~w_empty[bus.ch_sel];
                if (w_pop) w_pop_ch = bus.ch_sel;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_L-1:0] r_cnt;
        logic [PTR_L-1:0] r_ptr;
        logic             w_pop_hit;

        assign w_pop_hit = w_pop && (w_pop_ch == CH_L'(i));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_ptr <= '0;
            end else begin
                // Simultaneous push and pop leave the count unchanged.
                if (bus.push[i] && !w_pop_hit) begin
                    if (r_cnt != CNT_L'(MEM_SIZE)) r_cnt <= r_cnt + CNT_L'(1);
                end else if (!bus.push[i] && w_pop_hit) begin
                    r_cnt <= r_cnt - CNT_L'(1);
                end
                if (w_pop_hit)
                    r_ptr <= (r_ptr == PTR_L'(MEM_SIZE - 1)) ? '0 : r_ptr + PTR_L'(1);
            end
        end

        assign w_cnt[i]    = r_cnt;
        assign w_ptr[i]    = r_ptr;
        assign w_empty[i]  = (r_cnt == '0);
        assign w_aempty[i] = (r_cnt <= bus.ae_thresh);
        assign bus.occupancy[i*CNT_L +: CNT_L] = r_cnt;
`ifdef FIFO_RD_ERR_EN
        assign w_ovf_set[i] = bus.push[i] && !w_pop_hit && (r_cnt == CNT_L'(MEM_SIZE));
`endif
    end

    // last_grant resets to NUM_CH-1 so channel 0 has first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last        <= CH_L'(NUM_CH - 1);
            r_rd_valid    <= 1'b0;
            r_rd_valid_ch <= '0;
        end else begin
            if (w_pop && rd_mode_e'(bus.rr_mode) == MODE_RR) r_last <= w_pop_ch;
            r_rd_valid    <= w_pop;
            r_rd_valid_ch <= w_pop_ch;
        end
    end

`ifdef FIFO_RD_ERR_EN
    // Sticky errors; a set in the same cycle as err_clr wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_underflow <= 1'b0;
            r_err_overflow  <= '0;
        end else begin
            r_err_underflow <= (r_err_underflow & ~bus.err_clr) | (bus.fifo_rd & ~w_pop);
            r_err_overflow  <= (r_err_overflow & ~{NUM_CH{bus.err_clr}}) | w_ovf_set;
        end
    end

    assign bus.err_underflow = r_err_underflow;
    assign bus.err_overflow  = r_err_overflow;
`endif

    assign bus.pop          = w_pop;
    assign bus.pop_ch       = w_pop_ch;
    assign bus.rd_addr      = {w_pop_ch, w_ptr[w_pop_ch]};
    assign bus.fifo_empty   = w_empty;
    assign bus.almost_empty = w_aempty;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.rd_valid_ch  = r_rd_valid_ch;

endmodule

// File: tb/tb_fifo_rd_ctrl_mc.sv
// Bench for fifo_rd_ctrl_mc: directed scenarios followed by a randomized run,
// all compared against a queue-free array model of per-channel word counts,
// read positions and the round-robin rule.
module tb_fifo_rd_ctrl_mc;
    import fifo_rd_ctrl_mc_pkg::*;

    localparam int NUM_CH   = DEF_NUM_CH;
    localparam int MEM_SIZE = DEF_MEM_SIZE;
    localparam int PTR_L    = 2;
    localparam int CH_L     = 2;
    localparam int CNT_L    = 3;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fifo_rd_ctrl_mc_if #(.NUM_CH(NUM_CH), .PTR_L(PTR_L), .CH_L(CH_L), .CNT_L(CNT_L)) bus();

    fifo_rd_ctrl_mc #(
        .NUM_CH(NUM_CH), .MEM_SIZE(MEM_SIZE), .WORD_SIZE(DEF_WORD_SIZE),
        .PTR_L(PTR_L), .CH_L(CH_L), .CNT_L(CNT_L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    int               m_cnt [NUM_CH];
    int               m_ptr [NUM_CH];
    int               m_last;
    bit               m_rv;
    int               m_rv_ch;
    bit               m_eu;
    bit [NUM_CH-1:0]  m_eo;

    // Values observed at the most recent sample point
    logic                  o_pop;
    logic [CH_L-1:0]       o_ch;
    logic [CH_L+PTR_L-1:0] o_addr;
    logic [CH_L-1:0]       o_rvch;
    logic                  o_rv;
    logic [NUM_CH-1:0]     o_emp;
    logic [NUM_CH-1:0]     o_ae;

    int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0;
            m_ptr[c] = 0;
        end
        m_last  = NUM_CH - 1;
        m_rv    = 1'b0;
        m_rv_ch = 0;
        m_eu    = 1'b0;
        m_eo    = '0;
    endtask

    // One clock: drive inputs, check outputs on the falling edge, then advance
    // the model past the rising edge.
    task automatic tick(input bit rst, input logic [NUM_CH-1:0] psh, input bit rd,
                        input bit rr, input int sel, input int ae, input bit clr);
        bit                       e_pop;
        int                       e_ch;
        logic [NUM_CH*CNT_L-1:0]  e_occ;
        logic [NUM_CH-1:0]        e_emp;
        logic [NUM_CH-1:0]        e_ae;
        bit                       p;
        bit                       q;
        bit [NUM_CH-1:0]          set_o;
        int                       c;

        reset         = rst;
        bus.push      = psh;
        bus.fifo_rd   = rd;
        bus.rr_mode   = rr;
        bus.ch_sel    = sel[CH_L-1:0];
        bus.ae_thresh = ae[CNT_L-1:0];
`ifdef FIFO_RD_ERR_EN
        bus.err_clr   = clr;
`endif
        if (rst) model_reset();

        e_pop = 1'b0;
        e_ch  = 0;
        if (!rst && rd) begin
            if (rr) begin
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_last + k) % NUM_CH;
                    if (!e_pop && m_cnt[c] > 0) begin
                        e_pop = 1'b1;
                        e_ch  = c;
                    end
                end
            end else if (sel < NUM_CH && m_cnt[sel] > 0) begin
                e_pop = 1'b1;
                e_ch  = sel;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            e_occ[i*CNT_L +: CNT_L] = CNT_L'(m_cnt[i]);
            e_emp[i] = (m_cnt[i] == 0);
            e_ae[i]  = (m_cnt[i] <= ae);
        end

        @(negedge clk);
        o_pop  = bus.pop;
        o_ch   = bus.pop_ch;
        o_addr = bus.rd_addr;
        o_rv   = bus.rd_valid;
        o_rvch = bus.rd_valid_ch;
        o_emp  = bus.fifo_empty;
        o_ae   = bus.almost_empty;
        chk("pop",          32'(o_pop),  32'(e_pop));
        chk("pop_ch",       32'(o_ch),   e_ch);
        chk("rd_addr",      32'(o_addr), e_ch * (1 << PTR_L) + m_ptr[e_ch]);
        chk("fifo_empty",   32'(o_emp),  32'(e_emp));
        chk("almost_empty", 32'(o_ae),   32'(e_ae));
        chk("occupancy",    32'(bus.occupancy), 32'(e_occ));
        chk("rd_valid",     32'(o_rv),   32'(m_rv));
        chk("rd_valid_ch",  32'(o_rvch), m_rv_ch);
`ifdef FIFO_RD_ERR_EN
        chk("err_underflow", 32'(bus.err_underflow), 32'(m_eu));
        chk("err_overflow",  32'(bus.err_overflow),  32'(m_eo));
`endif

        @(posedge clk);
        #1;
        if (!rst) begin
            set_o = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                p = psh[i];
                q = e_pop && (e_ch == i);
                set_o[i] = p && !q && (m_cnt[i] == MEM_SIZE);
                if (p && !q && m_cnt[i] < MEM_SIZE) m_cnt[i]++;
                else if (!p && q) m_cnt[i]--;
                if (q) m_ptr[i] = (m_ptr[i] + 1) % MEM_SIZE;
            end
            if (e_pop && rr) m_last = e_ch;
            m_eu    = (m_eu && !clr) || (rd && !e_pop);
            m_eo    = (m_eo & ~{NUM_CH{clr}}) | set_o;
            m_rv    = e_pop;
            m_rv_ch = e_ch;
        end
    endtask

    initial begin
        logic [NUM_CH-1:0] r_psh;
        bit                r_rst;
        bit                r_rd;
        bit                r_rr;
        bit                r_clr;
        int                r_sel;
        int                r_ae;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.push = '0;
        bus.fifo_rd = 1'b0;
        bus.rr_mode = 1'b0;
        bus.ch_sel  = '0;
        bus.ae_thresh = '0;
`ifdef FIFO_RD_ERR_EN
        bus.err_clr = 1'b0;
`endif

        // Reset discards stored words in ch1; a read during reset does not pop.
        tick(1, 4'b0000, 0, 0, 0, 0, 0);
        repeat (3) tick(0, 4'b0010, 0, 0, 0, 0, 0);
        chk("t1_occ_ch1", 32'(bus.occupancy[CNT_L +: CNT_L]), 3);
        tick(1, 4'b0000, 1, 1, 0, 0, 0);
        chk("t1_empty", 32'(o_emp), 32'hF);
        chk("t1_pop", 32'(o_pop), 0);
        chk("t1_rv", 32'(o_rv), 0);
        chk("t1_occ_all", 32'(bus.occupancy), 0);

        // Fixed ch2: saturation, address sequence, empty read, wrap.
        tick(1, 4'b0000, 0, 0, 2, 0, 0);
        repeat (5) tick(0, 4'b0100, 0, 0, 2, 0, 0);
        chk("t2_sat", 32'(bus.occupancy[2*CNT_L +: CNT_L]), 4);
        for (int k = 0; k < 4; k++) begin
            tick(0, 4'b0000, 1, 0, 2, 0, 0);
            chk("t2_addr", 32'(o_addr), 8 + k);
        end
        tick(0, 4'b0000, 1, 0, 2, 0, 0);
        chk("t2_pop5", 32'(o_pop), 0);
`ifdef FIFO_RD_ERR_EN
        chk("t2_underflow", 32'(bus.err_underflow), 1);
`endif
        tick(0, 4'b0100, 0, 0, 2, 0, 0);
        tick(0, 4'b0000, 1, 0, 2, 0, 0);
        chk("t2_wrap", 32'(o_addr), 8);

        // Round-robin over ch0/1/3 with two words each.
        tick(1, 4'b0000, 0, 1, 0, 0, 0);
        repeat (2) tick(0, 4'b1011, 0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            tick(0, 4'b0000, 1, 1, 0, 0, 0);
            if (k < 6) begin
                chk("t3_pop", 32'(o_pop), 1);
                chk("t3_pop_ch", 32'(o_ch), rr_seq[k]);
            end else begin
                chk("t3_pop_end", 32'(o_pop), 0);
            end
            if (k > 0) chk("t3_rvch", 32'(o_rvch), rr_seq[k-1]);
        end

        // Push and pop of ch1 together.
        tick(1, 4'b0000, 0, 0, 1, 0, 0);
        repeat (2) tick(0, 4'b0010, 0, 0, 1, 0, 0);
        tick(0, 4'b0010, 1, 0, 1, 0, 0);
        chk("t4_addr0", 32'(o_addr), 4);
        chk("t4_cnt", 32'(bus.occupancy[CNT_L +: CNT_L]), 2);
        tick(0, 4'b0000, 1, 0, 1, 0, 0);
        chk("t4_addr1", 32'(o_addr), 5);

        // A push into an empty channel is not poppable in the same cycle.
        tick(1, 4'b0000, 0, 1, 0, 0, 0);
        tick(0, 4'b0001, 1, 1, 0, 0, 0);
        chk("t5_nopop", 32'(o_pop), 0);
        tick(0, 4'b0000, 1, 1, 0, 0, 0);
        chk("t5_pop", 32'(o_pop), 1);
        chk("t5_ch", 32'(o_ch), 0);

        // Almost-empty threshold 1 on ch3 while count goes 0,1,2,1.
        tick(1, 4'b0000, 0, 0, 3, 1, 0);
        tick(0, 4'b1000, 0, 0, 3, 1, 0);
        chk("t6_ae0", 32'(o_ae[3]), 1);  chk("t6_e0", 32'(o_emp[3]), 1);
        tick(0, 4'b1000, 0, 0, 3, 1, 0);
        chk("t6_ae1", 32'(o_ae[3]), 1);  chk("t6_e1", 32'(o_emp[3]), 0);
        tick(0, 4'b0000, 1, 0, 3, 1, 0);
        chk("t6_ae2", 32'(o_ae[3]), 0);  chk("t6_e2", 32'(o_emp[3]), 0);
        tick(0, 4'b0000, 0, 0, 3, 1, 0);
        chk("t6_ae3", 32'(o_ae[3]), 1);  chk("t6_e3", 32'(o_emp[3]), 0);

        // Randomized traffic, including occasional reset and error clear.
        tick(1, 4'b0000, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            r_rst = ($urandom_range(0, 79) == 0);
            r_psh = NUM_CH'($urandom);
            r_rd  = ($urandom_range(0, 3) != 0);
            r_rr  = $urandom_range(0, 1) == 1;
            r_sel = $urandom_range(0, 3);
            r_ae  = $urandom_range(0, 7);
            r_clr = ($urandom_range(0, 15) == 0);
            tick(r_rst, r_psh, r_rd, r_rr, r_sel, r_ae, r_clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
